// File: rtl/pwm_generator_8bit.sv
// Single-channel 8-bit PWM: 255-clock period counter compared against duty.
// Optional PWM_GLITCHFREE_UPDATE_EN latches duty only at the period boundary.
module pwm_generator_8bit (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] duty,
  output logic       pwm_out
);

  localparam logic [7:0] CNT_LAST = 8'd254;

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] duty_eff;
  logic       pwm_q, pwm_d;

`ifdef PWM_GLITCHFREE_UPDATE_EN
  logic [7:0] duty_q;

  // Shadow copy loads on the last count so a new duty starts cleanly at cnt=0.
  always_ff @(posedge clk) begin
    if (reset)                 duty_q <= 8'd0;
    else if (cnt_q == CNT_LAST) duty_q <= duty;
  end

  assign duty_eff = duty_q;
`else
  assign duty_eff = duty;
`endif

  // Counter never depends on duty, so an unknown duty cannot disturb it.
  assign cnt_d = (cnt_q == CNT_LAST) ? 8'd0 : cnt_q + 8'd1;
  assign pwm_d = (cnt_q < duty_eff);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_generator_8bit.sv
// Directed bench for pwm_generator_8bit: period-aligned duty table plus
// hand sequences for reset, mid-period duty change and mid-period reset.
module tb_pwm_generator_8bit;

  logic       clk;
  logic       reset;
  logic [7:0] duty;
  logic       pwm_out;

  int errors = 0;
  int checks = 0;

  pwm_generator_8bit dut (
    .clk    (clk),
    .reset  (reset),
    .duty   (duty),
    .pwm_out(pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int duty;
    int exp_high;   // high clocks expected in this period (live sampling)
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one 255-clock period with duty applied from its first edge; returns
  // the number of high clocks and the number of clocks deviating from the
  // ideal shape (high for the first n_exp clocks, low afterwards).
  task automatic run_period(input int d, input int n_exp, output int highs, output int bad);
    highs = 0;
    bad   = 0;
    duty  = d[7:0];
    for (int i = 0; i < 255; i++) begin
      tick();
      if (pwm_out) highs++;
      if (pwm_out !== (i < n_exp)) bad++;
    end
  endtask

  function automatic int eff(input int cur, input int prev);
`ifdef PWM_GLITCHFREE_UPDATE_EN
    return prev;
`else
    return cur;
`endif
  endfunction

  vec_t tbl[11];

  initial begin
    int highs, bad, prev, n;

    tbl[0]  = '{64, 64};
    tbl[1]  = '{64, 64};
    tbl[2]  = '{64, 64};
    tbl[3]  = '{128, 128};
    tbl[4]  = '{192, 192};
    tbl[5]  = '{255, 255};
    tbl[6]  = '{255, 255};
    tbl[7]  = '{0, 0};
    tbl[8]  = '{0, 0};
    tbl[9]  = '{1, 1};
    tbl[10] = '{254, 254};

    // Reset held for two edges with duty=128: output stays low.
    reset = 1'b1;
    duty  = 8'd128;
    tick();
    check("reset_edge1", int'(pwm_out), 0);
    tick();
    check("reset_edge2", int'(pwm_out), 0);
    reset = 1'b0;

    // First post-release edge compares cnt=0 against duty.
    tick();
    check("first_edge_after_release", int'(pwm_out), eff(128, 0) > 0 ? 1 : 0);
    highs = pwm_out ? 1 : 0;
    for (int i = 1; i < 255; i++) begin
      tick();
      if (pwm_out) highs++;
    end
    check("period0_high", highs, eff(128, 0));
    prev = 128;

    for (int i = 0; i < 11; i++) begin
`ifdef PWM_GLITCHFREE_UPDATE_EN
      n = prev;
`else
      n = tbl[i].exp_high;
`endif
      run_period(tbl[i].duty, n, highs, bad);
      check($sformatf("tbl%0d_d%0d_high", i, tbl[i].duty), highs, n);
      check($sformatf("tbl%0d_d%0d_shape", i, tbl[i].duty), bad, 0);
      prev = tbl[i].duty;
    end

    // Duty 64 -> 192 at cnt=30: live mode stretches the pulse, glitch-free
    // mode holds the old duty until the next period.
    run_period(64, eff(64, prev), highs, bad);
    check("pre_change_high", highs, eff(64, prev));
    duty  = 8'd64;
    highs = 0;
    for (int i = 0; i < 255; i++) begin
      if (i == 30) duty = 8'd192;
      tick();
      if (pwm_out) highs++;
    end
    check("mid_change_period_high", highs, eff(192, 64));
    run_period(192, 192, highs, bad);
    check("post_change_high", highs, 192);
    check("post_change_shape", bad, 0);

    // Reset in mid-period (cnt=100, duty=200).
    duty = 8'd200;
    for (int i = 0; i < 100; i++) tick();
    check("before_mid_reset", int'(pwm_out), 1);
    reset = 1'b1;
    tick();
    check("mid_reset_edge", int'(pwm_out), 0);
    reset = 1'b0;
    run_period(200, eff(200, 0), highs, bad);
    check("after_reset_p1_high", highs, eff(200, 0));
    check("after_reset_p1_shape", bad, 0);
    run_period(200, 200, highs, bad);
    check("after_reset_p2_high", highs, 200);
    check("after_reset_p2_shape", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
